// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_arbiter : round-robin CPU/debug arbiter for the single-port data memory
// Revision 1.0
// ============================================================================
module dmem_arbiter #(
  parameter int LATENCY = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_load,
  input  logic          cpu_store,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_done,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          memRead,
  output logic          data_memory_write,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STROBE = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic          last_owner_q, last_owner_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
  logic          cpu_req;

  assign cpu_req = cpu_load | cpu_store;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      owner_q      <= OWN_CPU;
      we_q         <= 1'b0;
      last_owner_q <= OWN_DBG;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      last_owner_q <= last_owner_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    we_d         = we_q;
    last_owner_d = last_owner_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    case (state_q)
      S_IDLE: begin
        // Under contention the requester that did not own the last access wins.
        if (cpu_req && (!dbg_req || last_owner_q == OWN_DBG)) begin
          owner_d     = OWN_CPU;
          we_d        = ~cpu_load;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
          cnt_d       = CNT_INIT;
          state_d     = S_STROBE;
        end else if (dbg_req) begin
          owner_d     = OWN_DBG;
          we_d        = dbg_we;
          mem_addr_d  = dbg_addr;
          mem_wdata_d = dbg_wdata;
          cnt_d       = CNT_INIT;
          state_d     = S_STROBE;
        end
      end
      S_STROBE: state_d = S_WAIT;
      S_WAIT: begin
        // Count reaches one in the cycle mem_rdata becomes valid.
        if (cnt_q == CNT_ONE) begin
          if (!we_q) begin
            if (owner_q == OWN_CPU) cpu_rdata_d = mem_rdata;
            else                    dbg_rdata_d = mem_rdata;
          end
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DONE: begin
        last_owner_d = owner_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    memRead           = (state_q == S_STROBE) & ~we_q;
    data_memory_write = (state_q == S_STROBE) & we_q;
    dbg_done          = (state_q == S_DONE) & (owner_q == OWN_DBG);
    cpu_stall         = cpu_req & ~((state_q == S_DONE) & (owner_q == OWN_CPU));
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dmem_arbiter : directed bench for dmem_arbiter with a fixed-latency memory
// Revision 1.0
// ============================================================================
module tb_dmem_arbiter;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_load, cpu_store, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_stall, dbg_done, memRead, data_memory_write;

  int n_vec = 0;
  int n_err = 0;

  logic        rd_pipe [LAT];
  logic [31:0] ad_pipe [LAT];

  always #5 clk = ~clk;

  dmem_arbiter #(.LATENCY(LAT), .AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_load(cpu_load), .cpu_store(cpu_store), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .memRead(memRead),
    .data_memory_write(data_memory_write), .mem_rdata(mem_rdata)
  );

  // Memory returns data exactly LAT cycles after memRead, garbage otherwise.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h10) ? 32'hCAFEF00D : ~a;
  endfunction

  always @(posedge clk) begin
    rd_pipe[0] <= memRead;
    ad_pipe[0] <= mem_addr;
    for (int i = 1; i < LAT; i++) begin
      rd_pipe[i] <= rd_pipe[i-1];
      ad_pipe[i] <= ad_pipe[i-1];
    end
  end

  assign mem_rdata = (rd_pipe[LAT-1] === 1'b1) ? mem_val(ad_pipe[LAT-1]) : 32'hBAD0BAD0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    for (int i = 0; i < LAT; i++) begin
      rd_pipe[i] = 1'b0;
      ad_pipe[i] = '0;
    end
    rst_n = 1'b0;
    cpu_load = 0; cpu_store = 0; dbg_req = 0; dbg_we = 0;
    cpu_addr = 0; cpu_wdata = 0; dbg_addr = 0; dbg_wdata = 0;
    #3;
    check("rst_memRead", {31'd0, memRead}, 32'd0);
    check("rst_write", {31'd0, data_memory_write}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_dbg_done", {31'd0, dbg_done}, 32'd0);
    check("rst_stall_idle", {31'd0, cpu_stall}, 32'd0);
    cpu_load = 1; #1;
    check("rst_stall_follows_req", {31'd0, cpu_stall}, 32'd1);
    cpu_load = 0;
    tick(); rst_n = 1'b1; tick();

    // Uncontested load
    cpu_load = 1; cpu_addr = 32'h10; #1;
    check("ld_c0_stall", {31'd0, cpu_stall}, 32'd1);
    check("ld_c0_memRead", {31'd0, memRead}, 32'd0);
    tick();
    check("ld_c1_memRead", {31'd0, memRead}, 32'd1);
    check("ld_c1_write", {31'd0, data_memory_write}, 32'd0);
    check("ld_c1_mem_addr", mem_addr, 32'h10);
    tick();
    check("ld_c2_memRead", {31'd0, memRead}, 32'd0);
    check("ld_c2_stall", {31'd0, cpu_stall}, 32'd1);
    tick();
    check("ld_c3_stall", {31'd0, cpu_stall}, 32'd1);
    tick();
    check("ld_c4_rdata", cpu_rdata, 32'hCAFEF00D);
    check("ld_c4_stall", {31'd0, cpu_stall}, 32'd0);
    cpu_load = 0;
    tick();

    // Store
    cpu_store = 1; cpu_addr = 32'h20; cpu_wdata = 32'h12345678;
    tick();
    check("st_c1_write", {31'd0, data_memory_write}, 32'd1);
    check("st_c1_memRead", {31'd0, memRead}, 32'd0);
    check("st_c1_mem_addr", mem_addr, 32'h20);
    check("st_c1_mem_wdata", mem_wdata, 32'h12345678);
    tick();
    check("st_c2_write", {31'd0, data_memory_write}, 32'd0);
    tick(); tick();
    check("st_c4_stall", {31'd0, cpu_stall}, 32'd0);
    check("st_c4_rdata_kept", cpu_rdata, 32'hCAFEF00D);
    cpu_store = 0;
    tick();

    // Simultaneous CPU/DBG after reset: CPU first
    do_reset();
    cpu_load = 1; cpu_addr = 32'h30;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h40;
    tick();
    check("ct_c1_memRead", {31'd0, memRead}, 32'd1);
    check("ct_c1_addr_cpu", mem_addr, 32'h30);
    tick(); tick(); tick();
    check("ct_c4_stall", {31'd0, cpu_stall}, 32'd0);
    check("ct_c4_cpu_rdata", cpu_rdata, 32'hFFFFFFCF);
    check("ct_c4_dbg_done", {31'd0, dbg_done}, 32'd0);
    cpu_load = 0;
    tick();
    check("ct_c5_memRead", {31'd0, memRead}, 32'd0);
    tick();
    check("ct_c6_memRead", {31'd0, memRead}, 32'd1);
    check("ct_c6_addr_dbg", mem_addr, 32'h40);
    tick(); tick();
    check("ct_c8_dbg_done", {31'd0, dbg_done}, 32'd0);
    tick();
    check("ct_c9_dbg_done", {31'd0, dbg_done}, 32'd1);
    check("ct_c9_dbg_rdata", dbg_rdata, 32'hFFFFFFBF);
    dbg_req = 0;
    tick();
    check("ct_c10_dbg_done", {31'd0, dbg_done}, 32'd0);

    // Continuous contention: CPU read / DBG write alternate
    cpu_load = 1; cpu_addr = 32'h50;
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h60; dbg_wdata = 32'h0000BEEF;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k % 2 == 0) begin
        check($sformatf("rr%0d_addr", k), mem_addr, 32'h50);
        check($sformatf("rr%0d_memRead", k), {31'd0, memRead}, 32'd1);
      end else begin
        check($sformatf("rr%0d_addr", k), mem_addr, 32'h60);
        check($sformatf("rr%0d_write", k), {31'd0, data_memory_write}, 32'd1);
        check($sformatf("rr%0d_wdata", k), mem_wdata, 32'h0000BEEF);
      end
      if (k == 3) begin
        cpu_load = 0; dbg_req = 0;
      end
      repeat (4) tick();
    end
    check("rr_dbg_rdata_kept", dbg_rdata, 32'hFFFFFFBF);
    check("rr_cpu_rdata", cpu_rdata, 32'hFFFFFFAF);

    // Load and store together: load wins
    cpu_load = 1; cpu_store = 1; cpu_addr = 32'h70; cpu_wdata = 32'h55555555;
    tick();
    check("ls_c1_memRead", {31'd0, memRead}, 32'd1);
    check("ls_c1_write", {31'd0, data_memory_write}, 32'd0);
    tick();
    check("ls_c2_write", {31'd0, data_memory_write}, 32'd0);
    tick(); tick();
    check("ls_c4_rdata", cpu_rdata, 32'hFFFFFF8F);
    cpu_load = 0; cpu_store = 0;
    tick();

    // Reset during WAIT
    cpu_load = 1; cpu_addr = 32'h80;
    tick(); tick();
    #1 rst_n = 1'b0; cpu_load = 0;
    #1;
    check("rw_mem_addr", mem_addr, 32'd0);
    check("rw_cpu_rdata", cpu_rdata, 32'd0);
    check("rw_memRead", {31'd0, memRead}, 32'd0);
    check("rw_stall", {31'd0, cpu_stall}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rw_no_done", {31'd0, dbg_done}, 32'd0);
    cpu_load = 1; cpu_addr = 32'h90;
    tick();
    check("rw2_c1_memRead", {31'd0, memRead}, 32'd1);
    tick(); tick();
    check("rw2_c3_stall", {31'd0, cpu_stall}, 32'd1);
    tick();
    check("rw2_c4_stall", {31'd0, cpu_stall}, 32'd0);
    check("rw2_c4_rdata", cpu_rdata, 32'hFFFFFF6F);
    cpu_load = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
